// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep sequencer: FSM states,
// sweep geometry constants and the vote helper.
package tt_sweep_pkg;

    localparam int ROWS        = 16;
    localparam int VOTES       = 3;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_EVAL   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Two-of-three vote, used to reject a single bad sample of the gate output.
    function automatic logic majority3(input logic [VOTES-1:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/tt_sweep_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous gate output into the clk domain.
module sync_2ff
    import tt_sweep_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] stage_q;

    // Shift the raw input through the flop chain; reset clears every stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/tt_sweep_sequencer.sv
// Truth-table sweep sequencer: drives all 16 input rows of a 4-input gate,
// majority-samples its synchronized output per row, assembles the observed
// table and compares it with the expected one.
module tt_sweep_sequencer
    import tt_sweep_pkg::*;
#(
    parameter logic [15:0] EXPECTED_TT   = 16'hB8AD,
    parameter int          SETTLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        circuit_out,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] observed_tt,
    output logic [15:0] mismatch
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_ROW    = 4'(ROWS - 1);
    localparam logic [1:0] LAST_VOTE   = 2'(VOTES - 1);

    state_e      state_q,     state_d;
    logic [3:0]  row_q,       row_d;
    logic [7:0]  settle_q,    settle_d;
    logic [1:0]  sampleCnt_q, sampleCnt_d;
    logic [2:0]  vote_q,      vote_d;
    logic [3:0]  drive_q,     drive_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        pass_q,      pass_d;
    logic [15:0] obs_q,       obs_d;
    logic [15:0] mis_q,       mis_d;
    logic        syncedOut;

    sync_2ff u_sync (
        .clk_i   (clk),
        .rst_i   (rst),
        .async_i (circuit_out),
        .sync_o  (syncedOut)
    );

    // Next-state logic for the sweep FSM and all datapath registers.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        settle_d    = settle_q;
        sampleCnt_d = sampleCnt_q;
        vote_d      = vote_q;
        drive_d     = drive_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        obs_d       = obs_q;
        mis_d       = mis_q;

        case (state_q)
            ST_IDLE: begin
                // busy is still high here only during the done pulse cycle,
                // so a start arriving then is dropped rather than queued.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    obs_d   = '0;
                    mis_d   = '0;
                    pass_d  = 1'b0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                drive_d  = row_q;
                settle_d = SETTLE_LOAD;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                settle_d = settle_q - 8'd1;
                if (settle_q == 8'd1) begin
                    sampleCnt_d = '0;
                    state_d     = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                vote_d      = {vote_q[1:0], syncedOut};
                sampleCnt_d = sampleCnt_q + 2'd1;
                if (sampleCnt_q == LAST_VOTE) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                obs_d[LAST_ROW - row_q] = majority3(vote_q);
                if (row_q == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 4'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                mis_d   = obs_q ^ EXPECTED_TT;
                pass_d  = (obs_q == EXPECTED_TT);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            settle_q    <= '0;
            sampleCnt_q <= '0;
            vote_q      <= '0;
            drive_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            obs_q       <= '0;
            mis_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            settle_q    <= settle_d;
            sampleCnt_q <= sampleCnt_d;
            vote_q      <= vote_d;
            drive_q     <= drive_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            obs_q       <= obs_d;
            mis_q       <= mis_d;
        end
    end

    assign in1         = drive_q[3];
    assign in2         = drive_q[2];
    assign in3         = drive_q[1];
    assign in4         = drive_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign observed_tt = obs_q;
    assign mismatch    = mis_q;

endmodule

// File: tb/tb_tt_sweep_sequencer.sv
// Bench for tt_sweep_sequencer: two instances (settle 8 and settle 3) driven by
// a behavioural gate model, checked every cycle against a timing/arithmetic
// reference model, plus directed literal checks and randomized sweeps.
module tb_tt_sweep_sequencer;

    localparam logic [15:0] TT   = 16'hB8AD;
    localparam int          HMAX = 16384;

    logic             clk;
    logic             rst;
    logic [1:0]       startV;
    logic [1:0]       coV;
    logic [1:0]       busyV;
    logic [1:0]       doneV;
    logic [1:0]       passV;
    logic [1:0][3:0]  pinV;
    logic [1:0][15:0] obsV;
    logic [1:0][15:0] misV;

    int compareCount = 0;
    int failCount    = 0;
    int cyc          = 0;
    bit modelValid   = 1'b0;

    logic [15:0] gateTt    = TT;
    int          lag       = 0;
    int          glitchCyc = -1;

    bit       coHist  [2][HMAX];
    bit [3:0] pinHist [2][HMAX];

    int          doneCount [2];
    bit          active    [2];
    int          kAcc      [2];
    logic        expBusy   [2];
    logic        expDone   [2];
    logic        expPass   [2];
    logic [15:0] expObs    [2];
    logic [15:0] expMis    [2];
    logic [3:0]  expRow    [2];

    tt_sweep_sequencer #(.EXPECTED_TT(TT), .SETTLE_CYCLES(8)) dutA (
        .clk(clk), .rst(rst), .start(startV[0]), .circuit_out(coV[0]),
        .in1(pinV[0][3]), .in2(pinV[0][2]), .in3(pinV[0][1]), .in4(pinV[0][0]),
        .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
        .observed_tt(obsV[0]), .mismatch(misV[0])
    );

    tt_sweep_sequencer #(.EXPECTED_TT(TT), .SETTLE_CYCLES(3)) dutB (
        .clk(clk), .rst(rst), .start(startV[1]), .circuit_out(coV[1]),
        .in1(pinV[1][3]), .in2(pinV[1][2]), .in3(pinV[1][1]), .in4(pinV[1][0]),
        .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
        .observed_tt(obsV[1]), .mismatch(misV[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int settleOf(input int d);
        return (d == 0) ? 8 : 3;
    endfunction

    function automatic logic maj(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: derives every output from the sweep timing rules.
    // A row r occupies SETTLE+5 cycles; its bit is the vote of the gate output
    // seen at edges k + r*per + SETTLE + {0,1,2} (two edges of sync latency).
    task automatic modelStep(input int d);
        int per, span, rel, r, base, rowv;
        per  = settleOf(d) + 5;
        span = 16 * per + 1;
        if (rst) begin
            active[d]  = 1'b0;
            expBusy[d] = 1'b0;
            expDone[d] = 1'b0;
            expPass[d] = 1'b0;
            expObs[d]  = '0;
            expMis[d]  = '0;
            expRow[d]  = '0;
            return;
        end
        expDone[d] = 1'b0;
        if (active[d]) begin
            rel = cyc - kAcc[d];
            if (rel >= 1 && rel <= span) begin
                rowv = (rel - 1) / per;
                expRow[d] = (rowv > 15) ? 4'd15 : 4'(rowv);
            end
            if (rel % per == 0 && rel / per >= 1 && rel / per <= 16) begin
                r    = rel / per - 1;
                base = kAcc[d] + r * per + settleOf(d);
                expObs[d][4'(15 - r)] = maj(coHist[d][base % HMAX],
                                            coHist[d][(base + 1) % HMAX],
                                            coHist[d][(base + 2) % HMAX]);
            end
            if (rel == span) begin
                expDone[d] = 1'b1;
                expMis[d]  = expObs[d] ^ TT;
                expPass[d] = (expObs[d] == TT);
            end
            if (rel == span + 1) begin
                active[d]  = 1'b0;
                expBusy[d] = 1'b0;
            end
        end else if (startV[d] === 1'b1) begin
            active[d]  = 1'b1;
            kAcc[d]    = cyc;
            expBusy[d] = 1'b1;
            expObs[d]  = '0;
            expMis[d]  = '0;
            expPass[d] = 1'b0;
        end
    endtask

    // Rising edge: record what the DUTs just sampled and advance the model.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) coHist[d][cyc % HMAX] = coV[d];
        if (rst === 1'b1) modelValid = 1'b1;
        for (int d = 0; d < 2; d++) modelStep(d);
        cyc = cyc + 1;
    end

    // Falling edge: compare every output, then drive the gate model.
    initial forever begin
        bit       v;
        bit [3:0] p;
        int       idx;
        @(negedge clk);
        if (modelValid) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("busy%0d", d), 32'(busyV[d]), 32'(expBusy[d]));
                checkOutput($sformatf("done%0d", d), 32'(doneV[d]), 32'(expDone[d]));
                checkOutput($sformatf("pass%0d", d), 32'(passV[d]), 32'(expPass[d]));
                checkOutput($sformatf("obs%0d", d),  32'(obsV[d]),  32'(expObs[d]));
                checkOutput($sformatf("mis%0d", d),  32'(misV[d]),  32'(expMis[d]));
                checkOutput($sformatf("pins%0d", d), 32'(pinV[d]),  32'(expRow[d]));
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (doneV[d] === 1'b1) doneCount[d]++;
            pinHist[d][cyc % HMAX] = pinV[d];
            idx = cyc - lag;
            p   = (idx >= 0) ? pinHist[d][idx % HMAX] : 4'd0;
            v   = gateTt[4'd15 - p];
            if (cyc == glitchCyc) v = ~v;
            coV[d] = v;
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] mask, output int k);
        startV = mask;
        k      = cyc;
        @(negedge clk);
        startV = 2'b00;
    endtask

    task automatic waitDone(input int d, input int budget, output int doneEdge);
        int n;
        n        = 0;
        doneEdge = -1;
        while (doneEdge < 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (doneV[d] === 1'b1) doneEdge = cyc - 1;
        end
        if (doneEdge < 0) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL done_timeout%0d: no done pulse, expected one within %0d cycles", d, budget);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (!(busyV === 2'b00 && !active[0] && !active[1]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            compareCount++;
            failCount++;
            $display("[TB] FAIL idle_timeout: busy=%b, expected 00 within %0d cycles", busyV, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k, de, dc;
        rst    = 1'b1;
        startV = 2'b00;
        coV    = 2'b00;
        for (int d = 0; d < 2; d++) doneCount[d] = 0;
        stepCycles(3);
        checkOutput("reset_busy", 32'(busyV), 32'd0);
        checkOutput("reset_obs",  32'(obsV[0]), 32'd0);
        checkOutput("reset_pins", 32'(pinV[0]), 32'd0);
        rst = 1'b0;
        stepCycles(2);

        // Nominal sweep on both instances.
        $display("[TB] nominal sweep");
        applyStimulus(2'b11, k);
        waitDone(1, 400, de);
        checkOutput("b_done_latency", 32'(de - k), 32'd129);
        checkOutput("b_obs", 32'(obsV[1]), 32'hB8AD);
        checkOutput("b_pass", 32'(passV[1]), 32'd1);
        waitDone(0, 400, de);
        checkOutput("a_done_latency", 32'(de - k), 32'd209);
        checkOutput("a_obs", 32'(obsV[0]), 32'hB8AD);
        checkOutput("a_mis", 32'(misV[0]), 32'h0000);
        checkOutput("a_pass", 32'(passV[0]), 32'd1);
        stepCycles(3);

        // Row 11 stuck high.
        $display("[TB] row 11 fault");
        gateTt = 16'hB8BD;
        stepCycles(3);
        applyStimulus(2'b01, k);
        waitDone(0, 400, de);
        checkOutput("fault_obs", 32'(obsV[0]), 32'hB8BD);
        checkOutput("fault_mis", 32'(misV[0]), 32'h0010);
        checkOutput("fault_pass", 32'(passV[0]), 32'd0);
        gateTt = TT;
        stepCycles(3);

        // One-cycle glitch landing on the second vote of row 0.
        $display("[TB] glitch rejection");
        applyStimulus(2'b01, k);
        glitchCyc = k + 8 + 1;
        waitDone(0, 400, de);
        checkOutput("glitch_obs", 32'(obsV[0]), 32'hB8AD);
        checkOutput("glitch_pass", 32'(passV[0]), 32'd1);
        glitchCyc = -1;
        stepCycles(3);

        // Start re-pulsed mid-sweep and around the done cycle.
        $display("[TB] start while busy");
        dc = doneCount[0];
        applyStimulus(2'b01, k);
        while (cyc < k + 50) @(negedge clk);
        startV[0] = 1'b1;
        @(negedge clk);
        startV[0] = 1'b0;
        checkOutput("repulse_busy", 32'(busyV[0]), 32'd1);
        while (cyc < k + 209) @(negedge clk);
        startV[0] = 1'b1;
        @(negedge clk);
        checkOutput("repulse_done", 32'(doneV[0]), 32'd1);
        @(negedge clk);
        startV[0] = 1'b0;
        checkOutput("repulse_busy_drop", 32'(busyV[0]), 32'd0);
        stepCycles(20);
        checkOutput("repulse_done_count", 32'(doneCount[0] - dc), 32'd1);

        // Reset in the middle of a sweep.
        $display("[TB] mid-sweep reset");
        dc = doneCount[0];
        applyStimulus(2'b01, k);
        while (cyc < k + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busyV[0]), 32'd0);
        checkOutput("rst_obs", 32'(obsV[0]), 32'd0);
        checkOutput("rst_pins", 32'(pinV[0]), 32'd0);
        checkOutput("rst_pass", 32'(passV[0]), 32'd0);
        stepCycles(250);
        checkOutput("rst_no_done", 32'(doneCount[0] - dc), 32'd0);
        applyStimulus(2'b01, k);
        waitDone(0, 400, de);
        checkOutput("rst_rerun_latency", 32'(de - k), 32'd209);
        checkOutput("rst_rerun_pass", 32'(passV[0]), 32'd1);
        stepCycles(3);

        // Gate output lagging its inputs by four cycles.
        $display("[TB] lagging gate");
        lag = 4;
        stepCycles(8);
        applyStimulus(2'b11, k);
        waitDone(1, 400, de);
        checkOutput("lag_b_obs", 32'(obsV[1]), 32'hDC56);
        checkOutput("lag_b_pass", 32'(passV[1]), 32'd0);
        waitDone(0, 400, de);
        checkOutput("lag_a_pass", 32'(passV[0]), 32'd1);
        lag = 0;
        stepCycles(8);

        // Randomized tables, lags, glitches, stray starts and resets.
        $display("[TB] random sweeps");
        for (int it = 0; it < 6; it++) begin
            gateTt    = 16'($urandom);
            lag       = int'($urandom_range(0, 5));
            stepCycles(int'($urandom_range(6, 10)));
            glitchCyc = cyc + int'($urandom_range(4, 150));
            applyStimulus(2'($urandom_range(1, 3)), k);
            repeat (int'($urandom_range(1, 3))) begin
                stepCycles(int'($urandom_range(1, 60)));
                startV = 2'($urandom_range(0, 3));
                @(negedge clk);
                startV = 2'b00;
            end
            if ($urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            waitIdle(1000);
            stepCycles(2);
        end
        glitchCyc = -1;
        lag       = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
